// File: rtl/vp_pkg.sv
// Shared opcode encodings, exec field layout and issue FSM state codes.
package vp_pkg;

  localparam logic [2:0] OP_MOV_S   = 3'b000;
  localparam logic [2:0] OP_MOV_SV  = 3'b001;
  localparam logic [2:0] OP_ADD_S   = 3'b010;
  localparam logic [2:0] OP_SUB_S   = 3'b011;
  localparam logic [2:0] OP_MUL_VS  = 3'b100;
  localparam logic [2:0] OP_ADD_VV  = 3'b101;
  localparam logic [2:0] OP_DIV_VS  = 3'b110;
  localparam logic [2:0] OP_SPECIAL = 3'b111;

  localparam int unsigned EXEC_W        = 5;
  localparam int unsigned EXEC_FUNC_BIT = 4;
  localparam int unsigned EXEC_OP_HI    = 3;
  localparam int unsigned EXEC_OP_LO    = 1;
  localparam int unsigned EXEC_IMM_BIT  = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCALAR = 2'd1;
  localparam logic [1:0] ST_VECTOR = 2'd2;

endpackage

// File: rtl/exec_classify.sv
// Pure combinational decode of an instruction into scalar / vector / illegal class.
module exec_classify
  import vp_pkg::*;
(
  input  logic       func,
  input  logic [2:0] op,
  output logic       is_scalar,
  output logic       is_vector,
  output logic       is_illegal
);

  always_comb begin
    is_scalar  = 1'b0;
    is_vector  = 1'b0;
    is_illegal = 1'b0;
    if (func) begin
      // Special class issues as a single NOP-like beat whatever the opcode.
      is_scalar = 1'b1;
    end else begin
      case (op)
        OP_MOV_S, OP_ADD_S, OP_SUB_S:              is_scalar  = 1'b1;
        OP_MOV_SV, OP_MUL_VS, OP_ADD_VV, OP_DIV_VS: is_vector  = 1'b1;
        default:                                   is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/exec_issue.sv
// Issue stage: holds one instruction and emits one scalar beat or VLEN vector lane beats.
module exec_issue
  import vp_pkg::*;
#(
  parameter int unsigned VLEN   = 8,
  parameter int unsigned LANE_W = $clog2(VLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_func,
  input  logic [2:0]        instr_op,
  input  logic              instr_imm,
  output logic              exec_valid,
  input  logic              exec_ready,
  output logic [EXEC_W-1:0] exec,
  output logic [LANE_W-1:0] lane,
  output logic              last,
  output logic              busy,
  output logic              illegal
);

  logic [1:0]        st_q, st_d;
  logic [LANE_W-1:0] cnt_q, cnt_d;
  logic              func_q, imm_q, illegal_q;
  logic [2:0]        op_q;
  logic              is_scalar, is_vector, is_illegal;
  logic              accept, last_lane;

  exec_classify u_classify (
    .func       (instr_func),
    .op         (instr_op),
    .is_scalar  (is_scalar),
    .is_vector  (is_vector),
    .is_illegal (is_illegal)
  );

  assign accept    = instr_valid && (st_q == ST_IDLE);
  assign last_lane = (cnt_q == LANE_W'(VLEN - 1));

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      ST_IDLE: begin
        if (accept && is_scalar) begin
          st_d = ST_SCALAR;
        end else if (accept && is_vector) begin
          st_d  = ST_VECTOR;
          cnt_d = '0;
        end
      end
      ST_SCALAR: begin
        if (exec_ready) st_d = ST_IDLE;
      end
      ST_VECTOR: begin
        if (exec_ready) begin
          if (last_lane) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + LANE_W'(1);
          end
        end
      end
      default: begin
        st_d  = ST_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      func_q    <= 1'b0;
      op_q      <= '0;
      imm_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      illegal_q <= accept && is_illegal;
      // Special class is normalised so exec never depends on the raw opcode or imm.
      if (accept && !is_illegal) begin
        func_q <= instr_func;
        op_q   <= instr_func ? OP_SPECIAL : instr_op;
        imm_q  <= instr_func ? 1'b0 : instr_imm;
      end
    end
  end

  assign instr_ready = (st_q == ST_IDLE);
  assign exec_valid  = (st_q == ST_SCALAR) || (st_q == ST_VECTOR);
  assign busy        = exec_valid;
  assign illegal     = illegal_q;
  assign lane        = (st_q == ST_VECTOR) ? cnt_q : '0;
  assign last        = (st_q == ST_SCALAR) || ((st_q == ST_VECTOR) && last_lane);

  always_comb begin
    exec = '0;
    if (exec_valid) begin
      exec[EXEC_FUNC_BIT]         = func_q;
      exec[EXEC_OP_HI:EXEC_OP_LO] = op_q;
      exec[EXEC_IMM_BIT]          = imm_q;
    end
  end

endmodule

// File: tb/tb_exec_issue.sv
// Table-driven bench for exec_issue with a beat scoreboard and corner-case sequences.
module tb_exec_issue;

  localparam int unsigned VLEN   = 8;
  localparam int unsigned LANE_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid, instr_ready, instr_func, instr_imm;
  logic [2:0]        instr_op;
  logic              exec_valid, exec_ready, last, busy, illegal;
  logic [4:0]        exec;
  logic [LANE_W-1:0] lane;

  exec_issue #(.VLEN(VLEN), .LANE_W(LANE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_func  (instr_func),
    .instr_op    (instr_op),
    .instr_imm   (instr_imm),
    .exec_valid  (exec_valid),
    .exec_ready  (exec_ready),
    .exec        (exec),
    .lane        (lane),
    .last        (last),
    .busy        (busy),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        exec;
    logic [LANE_W-1:0] lane;
    logic              last;
  } beat_t;

  typedef struct {
    logic       func;
    logic [2:0] op;
    logic       imm;
    logic [4:0] exp_exec;
    int         beats;
    logic       exp_ill;
  } vec_t;

  beat_t      exp_q[$];
  vec_t       tbl[11];
  int         errors = 0;
  int         checks = 0;
  int         valid_cycles;
  logic       ill_pending;
  logic [4:0] cur_exec;
  int         cur_beats;
  logic       cur_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, score the visible beat.
  task automatic step(input logic rdy, input logic v);
    beat_t b;
    @(negedge clk);
    exec_ready  = rdy;
    instr_valid = v;
    #1;
    chk("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
    chk("instr_ready", {31'd0, instr_ready}, {31'd0, exp_q.size() == 0});
    chk("exec_valid", {31'd0, exec_valid}, {31'd0, exp_q.size() != 0});
    chk("illegal", {31'd0, illegal}, {31'd0, ill_pending});
    ill_pending = 1'b0;
    if (exp_q.size() == 0) begin
      chk("idle_out", {23'd0, exec, lane, last}, 32'd0);
    end else begin
      b = exp_q[0];
      chk("exec", {27'd0, exec}, {27'd0, b.exec});
      chk("lane", {29'd0, lane}, {29'd0, b.lane});
      chk("last", {31'd0, last}, {31'd0, b.last});
      if (exec_valid) valid_cycles++;
      if (rdy) void'(exp_q.pop_front());
    end
    if (v && instr_ready) begin
      for (int k = 0; k < cur_beats; k++) begin
        b.exec = cur_exec;
        b.lane = (cur_beats == 1) ? '0 : LANE_W'(k);
        b.last = (k == cur_beats - 1);
        exp_q.push_back(b);
      end
      ill_pending = cur_ill;
    end
  endtask

  task automatic issue(input vec_t t, input int stall_lo, input int stall_hi);
    int c;
    instr_func = t.func;
    instr_op   = t.op;
    instr_imm  = t.imm;
    cur_exec   = t.exp_exec;
    cur_beats  = t.beats;
    cur_ill    = t.exp_ill;
    step(1'b1, 1'b1);
    c = 1;
    while (exp_q.size() != 0 && c <= 40) begin
      step(!(c >= stall_lo && c <= stall_hi), 1'b0);
      c++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    step(1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 3'b000, 1'b0, 5'b0_000_0, 1, 1'b0};
    tbl[1]  = '{1'b0, 3'b000, 1'b1, 5'b0_000_1, 1, 1'b0};
    tbl[2]  = '{1'b0, 3'b001, 1'b1, 5'b0_001_1, 8, 1'b0};
    tbl[3]  = '{1'b0, 3'b010, 1'b1, 5'b0_010_1, 1, 1'b0};
    tbl[4]  = '{1'b0, 3'b011, 1'b0, 5'b0_011_0, 1, 1'b0};
    tbl[5]  = '{1'b0, 3'b100, 1'b1, 5'b0_100_1, 8, 1'b0};
    tbl[6]  = '{1'b0, 3'b101, 1'b0, 5'b0_101_0, 8, 1'b0};
    tbl[7]  = '{1'b0, 3'b110, 1'b1, 5'b0_110_1, 8, 1'b0};
    tbl[8]  = '{1'b0, 3'b111, 1'b0, 5'b0_000_0, 0, 1'b1};
    tbl[9]  = '{1'b1, 3'b010, 1'b1, 5'b1_111_0, 1, 1'b0};
    tbl[10] = '{1'b1, 3'b111, 1'b1, 5'b1_111_0, 1, 1'b0};

    ill_pending = 1'b0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_func  = 1'b0;
    instr_op    = 3'b000;
    instr_imm   = 1'b0;
    exec_ready  = 1'b0;
    #12;
    chk("rst_exec_valid", {31'd0, exec_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_outputs", {23'd0, exec, lane, last}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);

    for (int i = 0; i < 11; i++) issue(tbl[i], 0, -1);

    // Backpressure: lane 2 held through burst cycles 3 and 4.
    valid_cycles = 0;
    issue(tbl[5], 3, 4);
    chk("bp_cycles", valid_cycles, 32'd10);

    // Reset in the middle of a DIV burst.
    instr_func = 1'b0;
    instr_op   = 3'b110;
    instr_imm  = 1'b0;
    cur_exec   = 5'b0_110_0;
    cur_beats  = 8;
    cur_ill    = 1'b0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    @(negedge clk);
    exec_ready = 1'b1;
    #1;
    chk("mid_lane", {29'd0, lane}, 32'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, exec_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    ill_pending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    issue(tbl[6], 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
